// File: rtl/writeback_scheduler_pkg.sv
// rtl/writeback_scheduler_pkg.sv - shared encodings and wheel-entry type for the writeback scheduler
package writeback_scheduler_pkg;

  // Register-file write class, also used on rwout
  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_GPR  = 2'b01;
  localparam logic [1:0] RW_FPR  = 2'b10;
  localparam logic [1:0] RW_RSVD = 2'b11;

  // Result source selecting which unit's data bus is written back
  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_MEM = 2'b01;
  localparam logic [1:0] CLS_FPU = 2'b10;

  // One latency-wheel slot; an empty slot is kept all-zero so rwout/rdout read 0
  typedef struct packed {
    logic       valid;
    logic [1:0] rw;
    logic [4:0] rd;
    logic [1:0] cls;
  } wb_entry_t;

  // Scoreboard query key: bit5 selects the fpr file, bits4:0 the index
  function automatic logic [5:0] entry_key(input wb_entry_t e);
    return {e.rw == RW_FPR, e.rd};
  endfunction

endpackage

// File: rtl/writeback_scheduler_scoreboard.sv
// rtl/writeback_scheduler_scoreboard.sv - pending-write lookup for one register query port
module wb_scoreboard
  import writeback_scheduler_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  wb_entry_t [DEPTH-1:0] slots,
  input  logic [5:0]            query,
  output logic                  busy
);

  // OR of key matches over slots 1..DEPTH-1; slot 0 is retiring and is forwarded by decode
  always_comb begin
    busy = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      if (slots[k].valid && (entry_key(slots[k]) == query)) begin
        busy = 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_scheduler.sv
// rtl/writeback_scheduler.sv - latency-wheel writeback scheduler with register scoreboard
module writeback_scheduler
  import writeback_scheduler_pkg::*;
#(
  parameter int WHEEL_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        issue_valid,
  input  logic [1:0]  issue_rw,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  issue_wait,
  input  logic [1:0]  issue_cls,
  output logic        issue_ready,
  input  logic [31:0] alu_data,
  input  logic [31:0] mem_data,
  input  logic [31:0] fpu_data,
  output logic [1:0]  rwout,
  output logic [4:0]  rdout,
  output logic [31:0] dtowrite,
  input  logic [5:0]  rs_q,
  input  logic [5:0]  rt_q,
  output logic        busy_s,
  output logic        busy_t
);

  wb_entry_t [WHEEL_DEPTH-1:0] wheel;
  wb_entry_t [WHEEL_DEPTH-1:0] wheel_nxt;
  wb_entry_t                   new_entry;

  logic [4:0] wait_eff;
  logic       wait_ok;
  logic       collide;
  logic       do_insert;

  // A zero latency still needs one cycle to reach the retire slot
  assign wait_eff = (issue_wait == 5'd0) ? 5'd1 : issue_wait;
  assign wait_ok  = (int'(wait_eff) <= WHEEL_DEPTH - 1);

  // Collision: the slot that will shift into position wait_eff-1 is already taken
  always_comb begin
    collide = 1'b0;
    for (int k = 1; k < WHEEL_DEPTH; k++) begin
      if ((int'(wait_eff) == k) && wheel[k].valid) begin
        collide = 1'b1;
      end
    end
  end

  // Acceptance decision; no-write issues never stall, reserved class and long latency always do
  always_comb begin
    issue_ready = 1'b1;
    if (!rstn) begin
      issue_ready = 1'b0;
    end else if (!issue_valid) begin
      issue_ready = 1'b1;
    end else if (issue_rw == RW_NONE) begin
      issue_ready = 1'b1;
    end else if ((issue_rw == RW_RSVD) || !wait_ok) begin
      issue_ready = 1'b0;
    end else begin
      issue_ready = !collide;
    end
  end

  // Only real register writes enter the wheel; gpr 0 is a sink and is dropped
  assign do_insert = issue_valid && issue_ready &&
                     ((issue_rw == RW_FPR) ||
                      ((issue_rw == RW_GPR) && (issue_rd != 5'd0)));

  assign new_entry = '{valid: 1'b1, rw: issue_rw, rd: issue_rd, cls: issue_cls};

  // Shift every slot down by one and drop the new entry into slot wait_eff-1
  always_comb begin
    wheel_nxt = '0;
    for (int k = 0; k < WHEEL_DEPTH - 1; k++) begin
      wheel_nxt[k] = wheel[k+1];
    end
    if (do_insert) begin
      for (int k = 0; k < WHEEL_DEPTH - 1; k++) begin
        if (int'(wait_eff) == k + 1) begin
          wheel_nxt[k] = new_entry;
        end
      end
    end
  end

  // Wheel register; reset discards every in-flight write
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wheel <= '0;
    end else begin
      wheel <= wheel_nxt;
    end
  end

  assign rwout = wheel[0].rw;
  assign rdout = wheel[0].rd;

  // Retire data is taken from whichever unit produced the slot-0 result
  always_comb begin
    dtowrite = 32'd0;
    if (wheel[0].valid) begin
      case (wheel[0].cls)
        CLS_ALU: dtowrite = alu_data;
        CLS_MEM: dtowrite = mem_data;
        CLS_FPU: dtowrite = fpu_data;
        default: dtowrite = 32'd0;
      endcase
    end
  end

  wb_scoreboard #(.DEPTH(WHEEL_DEPTH)) u_sb_s (
    .slots (wheel),
    .query (rs_q),
    .busy  (busy_s)
  );

  wb_scoreboard #(.DEPTH(WHEEL_DEPTH)) u_sb_t (
    .slots (wheel),
    .query (rt_q),
    .busy  (busy_t)
  );

endmodule

// File: tb/tb_writeback_scheduler.sv
// tb/tb_writeback_scheduler.sv - self-checking bench for writeback_scheduler against a pending-write list model
module tb_writeback_scheduler;

  localparam int D = 16;

  logic        clk;
  logic        rstn;
  logic        issue_valid;
  logic [1:0]  issue_rw;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_wait;
  logic [1:0]  issue_cls;
  logic        issue_ready;
  logic [31:0] alu_data;
  logic [31:0] mem_data;
  logic [31:0] fpu_data;
  logic [1:0]  rwout;
  logic [4:0]  rdout;
  logic [31:0] dtowrite;
  logic [5:0]  rs_q;
  logic [5:0]  rt_q;
  logic        busy_s;
  logic        busy_t;

  writeback_scheduler #(.WHEEL_DEPTH(D)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .issue_valid (issue_valid),
    .issue_rw    (issue_rw),
    .issue_rd    (issue_rd),
    .issue_wait  (issue_wait),
    .issue_cls   (issue_cls),
    .issue_ready (issue_ready),
    .alu_data    (alu_data),
    .mem_data    (mem_data),
    .fpu_data    (fpu_data),
    .rwout       (rwout),
    .rdout       (rdout),
    .dtowrite    (dtowrite),
    .rs_q        (rs_q),
    .rt_q        (rt_q),
    .busy_s      (busy_s),
    .busy_t      (busy_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each pending write remembers the absolute cycle in which it retires
  typedef struct {
    int         ret;
    logic [1:0] rw;
    logic [4:0] rd;
    logic [1:0] cls;
  } pend_t;

  pend_t pend[$];
  int    cyc;
  int    total;
  int    bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic model_busy(input logic [5:0] q);
    logic b;
    b = 1'b0;
    foreach (pend[i]) begin
      if ((pend[i].ret > cyc) && (q[5] == (pend[i].rw == 2'b10)) && (q[4:0] == pend[i].rd))
        b = 1'b1;
    end
    return b;
  endfunction

  // One clock cycle: apply inputs, check every output against the model, then advance
  task automatic cycle(input logic r, input logic v, input logic [1:0] rw, input logic [4:0] rd,
                       input logic [4:0] wt, input logic [1:0] cls,
                       input logic [5:0] qs, input logic [5:0] qt);
    logic [1:0]  e_rw;
    logic [4:0]  e_rd;
    logic [31:0] e_d;
    logic        e_rdy;
    logic        taken;
    logic        ins;
    int          w;
    @(negedge clk);
    rstn = r; issue_valid = v; issue_rw = rw; issue_rd = rd; issue_wait = wt; issue_cls = cls;
    rs_q = qs; rt_q = qt;
    alu_data = $urandom; mem_data = $urandom; fpu_data = $urandom;
    #1;
    e_rw = 2'b00; e_rd = 5'd0; e_d = 32'd0;
    foreach (pend[i]) begin
      if (pend[i].ret == cyc) begin
        e_rw = pend[i].rw;
        e_rd = pend[i].rd;
        e_d  = (pend[i].cls == 2'd0) ? alu_data :
               (pend[i].cls == 2'd1) ? mem_data :
               (pend[i].cls == 2'd2) ? fpu_data : 32'd0;
      end
    end
    w = (wt == 5'd0) ? 1 : int'(wt);
    taken = 1'b0;
    foreach (pend[i]) if (pend[i].ret == cyc + w) taken = 1'b1;
    if (!r)              e_rdy = 1'b0;
    else if (!v)         e_rdy = 1'b1;
    else if (rw == 2'b00) e_rdy = 1'b1;
    else if (rw == 2'b11 || w > D - 1) e_rdy = 1'b0;
    else                 e_rdy = !taken;
    chk("rwout", 32'(rwout), 32'(e_rw));
    chk("rdout", 32'(rdout), 32'(e_rd));
    chk("dtowrite", dtowrite, e_d);
    chk("issue_ready", 32'(issue_ready), 32'(e_rdy));
    chk("busy_s", 32'(busy_s), 32'(model_busy(qs)));
    chk("busy_t", 32'(busy_t), 32'(model_busy(qt)));
    ins = r && v && e_rdy && (rw == 2'b10 || (rw == 2'b01 && rd != 5'd0));
    @(posedge clk);
    if (!r) begin
      pend.delete();
    end else begin
      for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].ret <= cyc) pend.delete(i);
      if (ins) pend.push_back('{ret: cyc + w, rw: rw, rd: rd, cls: cls});
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic [5:0] qs, input logic [5:0] qt);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 2'd0, qs, qt);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 2'b01, 5'd4, 5'd2, 2'd0, 6'h04, 6'h00);
  endtask

  initial begin
    logic [1:0] rrw;
    logic [4:0] rrd;
    logic [4:0] rwt;
    logic [5:0] qs;
    logic [5:0] qt;
    cyc = 0; total = 0; bad = 0;
    rstn = 1'b0; issue_valid = 1'b0; issue_rw = 2'b00; issue_rd = 5'd0; issue_wait = 5'd0;
    issue_cls = 2'd0; rs_q = 6'd0; rt_q = 6'd0; alu_data = 32'd0; mem_data = 32'd0; fpu_data = 32'd0;

    // Reset: outputs quiet and no issue accepted
    do_reset(3);

    // gpr rd5 wait1 alu retires the next cycle
    cycle(1'b1, 1'b1, 2'b01, 5'd5, 5'd1, 2'd0, 6'h05, 6'h00);
    idle(2, 6'h05, 6'h00);

    // fpr rd3 wait6 fpu, busy on 0x23 until it reaches slot 0
    cycle(1'b1, 1'b1, 2'b10, 5'd3, 5'd6, 2'd2, 6'h23, 6'h03);
    idle(7, 6'h23, 6'h03);

    // Collision: wait6 at t0 then wait3 at t3 is refused
    cycle(1'b1, 1'b1, 2'b01, 5'd10, 5'd6, 2'd0, 6'h0a, 6'h0b);
    idle(2, 6'h0a, 6'h0b);
    cycle(1'b1, 1'b1, 2'b01, 5'd11, 5'd3, 2'd1, 6'h0a, 6'h0b);
    idle(5, 6'h0a, 6'h0b);
    // Same opening, retry with wait4 is accepted and retires at t7
    cycle(1'b1, 1'b1, 2'b01, 5'd10, 5'd6, 2'd0, 6'h0a, 6'h0b);
    idle(2, 6'h0a, 6'h0b);
    cycle(1'b1, 1'b1, 2'b01, 5'd11, 5'd4, 2'd1, 6'h0a, 6'h0b);
    idle(6, 6'h0a, 6'h0b);

    // gpr 0 is dropped; over-long and reserved issues are refused; wait0 acts as wait1
    cycle(1'b1, 1'b1, 2'b01, 5'd0, 5'd1, 2'd0, 6'h00, 6'h20);
    cycle(1'b1, 1'b1, 2'b01, 5'd6, 5'd20, 2'd0, 6'h00, 6'h06);
    cycle(1'b1, 1'b1, 2'b11, 5'd6, 5'd2, 2'd0, 6'h00, 6'h06);
    cycle(1'b1, 1'b1, 2'b10, 5'd8, 5'd15, 2'd2, 6'h28, 6'h06);
    cycle(1'b1, 1'b1, 2'b01, 5'd6, 5'd0, 2'd1, 6'h28, 6'h06);
    idle(16, 6'h28, 6'h06);

    // Reset mid-flight discards the pending mem write
    cycle(1'b1, 1'b1, 2'b01, 5'd7, 5'd3, 2'd1, 6'h07, 6'h07);
    cycle(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 2'd0, 6'h07, 6'h07);
    idle(3, 6'h07, 6'h07);

    // WAW on rd9: wait1 at t2 collides, wait2 at t2 retires after the first
    cycle(1'b1, 1'b1, 2'b01, 5'd9, 5'd3, 2'd0, 6'h09, 6'h09);
    idle(1, 6'h09, 6'h09);
    cycle(1'b1, 1'b1, 2'b01, 5'd9, 5'd1, 2'd1, 6'h09, 6'h09);
    idle(3, 6'h09, 6'h09);
    cycle(1'b1, 1'b1, 2'b01, 5'd9, 5'd3, 2'd0, 6'h09, 6'h09);
    idle(1, 6'h09, 6'h09);
    cycle(1'b1, 1'b1, 2'b01, 5'd9, 5'd2, 2'd1, 6'h09, 6'h09);
    idle(4, 6'h09, 6'h09);

    // Issue of rd12 in the same cycle rd12 retires: output and new busy both happen
    cycle(1'b1, 1'b1, 2'b10, 5'd12, 5'd2, 2'd2, 6'h2c, 6'h0c);
    idle(1, 6'h2c, 6'h0c);
    cycle(1'b1, 1'b1, 2'b10, 5'd12, 5'd3, 2'd2, 6'h2c, 6'h0c);
    idle(4, 6'h2c, 6'h0c);

    // rw=00 is accepted even when its slot is occupied
    cycle(1'b1, 1'b1, 2'b10, 5'd1, 5'd4, 2'd2, 6'h21, 6'h01);
    cycle(1'b1, 1'b1, 2'b00, 5'd1, 5'd3, 2'd0, 6'h21, 6'h01);
    idle(4, 6'h21, 6'h01);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      rrw = 2'($urandom_range(0, 3));
      rrd = 5'($urandom_range(0, 31));
      if (rrw == 2'b01 && rrd == 5'd0) rrd = 5'd1;
      rwt = (rrw == 2'b00) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(0, 17));
      qs = 6'($urandom_range(0, 63));
      qt = 6'($urandom_range(0, 63));
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        qs = {pend[0].rw == 2'b10, pend[0].rd};
        qt = {pend[pend.size()-1].rw == 2'b10, pend[pend.size()-1].rd};
      end
      cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), rrw, rrd, rwt,
            2'($urandom_range(0, 2)), qs, qt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
